// File: rtl/gpio_vector_checker.sv
// gpio_vector_checker
//
// On-chip vector runner for a GPIO-facing DUT. A table of vectors is loaded
// while idle; a start pulse then walks the first num_vec entries. Each vector
// drives dut_in/dut_rst for one APPLY cycle, waits SETTLE cycles, then
// compares dut_out against the expected word under cmp_mask. Mismatches are
// counted (saturating) and the first one is captured with its index and
// observed value.
//
// Ports:
//   clk2              clock, rising edge
//   rst               synchronous reset, active-low
//   load_en           table write strobe (honoured only when not busy)
//   load_addr         table write index (indices >= DEPTH are dropped)
//   load_data         {dut_rst_flag, in_word, exp_word}
//   num_vec           number of vectors to run, latched at start
//   start             one-cycle run request (ignored while busy)
//   cmp_mask          per-bit compare enable, latched at start
//   dut_out           observed DUT output
//   dut_in            word driven to the DUT input
//   dut_rst           reset driven to the DUT (active-high)
//   busy              run in progress
//   done              run finished, held until next start or reset
//   pass              valid with done: no mismatches counted
//   err_count         saturating mismatch count
//   vec_idx           index of the vector currently applied
//   first_fail_valid  a mismatch has been captured
//   first_fail_idx    index of the first mismatch
//   first_fail_obs    dut_out at the first mismatch
module gpio_vector_checker #(
  parameter int IN_W         = 32,
  parameter int OUT_W        = 32,
  parameter int DEPTH        = 150,
  parameter int ADDR_W       = 8,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0,
  parameter int SETTLE       = 4
) (
  input  logic                 clk2,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [IN_W+OUT_W:0]  load_data,
  input  logic [ADDR_W:0]      num_vec,
  input  logic                 start,
  input  logic [OUT_W-1:0]     cmp_mask,
  input  logic [OUT_W-1:0]     dut_out,
  output logic [IN_W-1:0]      dut_in,
  output logic                 dut_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    vec_idx,
  output logic                 first_fail_valid,
  output logic [ADDR_W-1:0]    first_fail_idx,
  output logic [OUT_W-1:0]     first_fail_obs
);

  localparam int VEC_W = 1 + IN_W + OUT_W;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [ADDR_W:0]  DEPTH_N  = (ADDR_W + 1)'(DEPTH);
  localparam logic [SET_W-1:0] SETTLE_N = SET_W'(SETTLE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  // Vector storage; deliberately not reset so a table survives a reset.
  logic [VEC_W-1:0] table_mem [DEPTH];

  logic [ADDR_W:0]     num_lat;
  logic [OUT_W-1:0]    mask_lat;
  logic [SET_W-1:0]    settle_cnt;

  logic [VEC_W-1:0]    vec_cur;
  logic                cur_flag;
  logic [IN_W-1:0]     cur_in;
  logic [OUT_W-1:0]    cur_exp;
  logic                mismatch;
  logic                last_vec;
  logic                finish;
  logic                start_empty;
  logic [ADDR_W:0]     num_clamped;
  logic [CNT_W-1:0]    err_upd;
  logic                write_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Current vector fields
  assign vec_cur  = table_mem[vec_idx];
  assign cur_flag = vec_cur[VEC_W-1];
  assign cur_in   = vec_cur[IN_W+OUT_W-1:OUT_W];
  assign cur_exp  = vec_cur[OUT_W-1:0];

  // Vectors that hold the DUT in reset are never scored.
  assign mismatch = !cur_flag && (((dut_out ^ cur_exp) & mask_lat) != '0);
  assign err_upd  = mismatch ? sat_inc(err_count) : err_count;

  // num_lat is never 0 inside a run, so num_lat-1 cannot underflow here.
  assign last_vec = ({1'b0, vec_idx} == (num_lat - (ADDR_W + 1)'(1)));
  assign finish   = last_vec || ((STOP_ON_FAIL != 0) && mismatch);

  // A request larger than the table is clipped so the index stays in range.
  assign num_clamped = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign start_empty = (num_vec == '0);

  assign busy = (state == ST_APPLY) || (state == ST_SETTLE) ||
                (state == ST_CHECK);

  assign write_ok = rst && load_en && !busy &&
                    ({1'b0, load_addr} < DEPTH_N);

  // Table write port
  always_ff @(posedge clk2) begin
    if (write_ok) begin
      table_mem[load_addr] <= load_data;
    end
  end

  // State register
  always_ff @(posedge clk2) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = start_empty ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == SET_W'(1)) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_nxt = finish ? ST_DONE : ST_APPLY;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Run datapath and result registers
  always_ff @(posedge clk2) begin
    if (!rst) begin
      dut_in           <= '0;
      dut_rst          <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      vec_idx          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_obs   <= '0;
      num_lat          <= '0;
      mask_lat         <= '0;
      settle_cnt       <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_lat          <= num_clamped;
            mask_lat         <= cmp_mask;
            err_count        <= '0;
            vec_idx          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_obs   <= '0;
            // An empty run completes immediately as a pass.
            done             <= start_empty;
            pass             <= start_empty;
          end
        end
        ST_APPLY: begin
          dut_in     <= cur_in;
          dut_rst    <= cur_flag;
          settle_cnt <= SETTLE_N;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - SET_W'(1);
        end
        ST_CHECK: begin
          err_count <= err_upd;
          if (mismatch && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= vec_idx;
            first_fail_obs   <= dut_out;
          end
          if (finish) begin
            done <= 1'b1;
            pass <= (err_upd == '0);
          end else begin
            vec_idx <= vec_idx + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_vector_checker.sv
// Testbench for gpio_vector_checker. Three instances share the load/start
// bus: d0 default build, d1 with STOP_ON_FAIL=1, d2 with a 2-bit error counter
// to reach saturation. Each DUT output is looped back to its dut_out.
module tb_gpio_vector_checker;

  localparam int DEPTH  = 150;
  localparam int SETTLE = 4;
  localparam int TMO    = 300;

  logic         clk2;
  logic         rst;
  logic         load_en;
  logic [7:0]   load_addr;
  logic [64:0]  load_data;
  logic [8:0]   num_vec;
  logic         start;
  logic [31:0]  cmp_mask;

  logic [31:0]  din_s  [3];
  logic         drst_s [3];
  logic         busy_s [3];
  logic         done_s [3];
  logic         pass_s [3];
  logic [7:0]   idx_s  [3];
  logic         ffv_s  [3];
  logic [7:0]   ffi_s  [3];
  logic [31:0]  ffo_s  [3];
  logic [15:0]  err_a, err_b;
  logic [1:0]   err_c;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // Reference table as the bench believes it to be
  logic        tb_flag [DEPTH];
  logic [31:0] tb_in   [DEPTH];
  logic [31:0] tb_exp  [DEPTH];

  typedef struct {
    int          start_cyc;
    int          lat;
    logic [31:0] err;
    logic        pass;
    logic        ffv;
    logic [7:0]  ffi;
    logic [31:0] ffo;
    logic [7:0]  last_idx;
    logic [31:0] last_in;
    logic        chk_in;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  gpio_vector_checker #(.STOP_ON_FAIL(0)) d0 (
    .clk2(clk2), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start),
    .cmp_mask(cmp_mask), .dut_out(din_s[0]), .dut_in(din_s[0]),
    .dut_rst(drst_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .err_count(err_a), .vec_idx(idx_s[0]),
    .first_fail_valid(ffv_s[0]), .first_fail_idx(ffi_s[0]),
    .first_fail_obs(ffo_s[0]));

  gpio_vector_checker #(.STOP_ON_FAIL(1)) d1 (
    .clk2(clk2), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start),
    .cmp_mask(cmp_mask), .dut_out(din_s[1]), .dut_in(din_s[1]),
    .dut_rst(drst_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .err_count(err_b), .vec_idx(idx_s[1]),
    .first_fail_valid(ffv_s[1]), .first_fail_idx(ffi_s[1]),
    .first_fail_obs(ffo_s[1]));

  gpio_vector_checker #(.STOP_ON_FAIL(0), .CNT_W(2)) d2 (
    .clk2(clk2), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start),
    .cmp_mask(cmp_mask), .dut_out(din_s[2]), .dut_in(din_s[2]),
    .dut_rst(drst_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .pass(pass_s[2]), .err_count(err_c), .vec_idx(idx_s[2]),
    .first_fail_valid(ffv_s[2]), .first_fail_idx(ffi_s[2]),
    .first_fail_obs(ffo_s[2]));

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  always @(posedge clk2) cyc <= cyc + 1;

  function automatic logic [31:0] get_err(input int k);
    if (k == 0) return {16'd0, err_a};
    if (k == 1) return {16'd0, err_b};
    return {30'd0, err_c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Expected outcome of a run, from the table walk described by the rules:
  // score unflagged vectors under the mask, saturate, optionally stop early.
  function automatic exp_t model(input int k, input int num,
                                 input logic [31:0] mask);
    exp_t e;
    int   cnt  = 0;
    int   cmax = (k == 2) ? 3 : 65535;
    int   last = 0;
    bit   stop = 0;
    e.start_cyc = 0;
    e.ffv = 1'b0;
    e.ffi = '0;
    e.ffo = '0;
    e.lat = 1;
    for (int i = 0; i < num && !stop; i++) begin
      last = i;
      if (!tb_flag[i] && (((tb_in[i] ^ tb_exp[i]) & mask) != 32'd0)) begin
        if (cnt < cmax) cnt++;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffi = i[7:0];
          e.ffo = tb_in[i];
        end
        if (k == 1) stop = 1;
      end
      e.lat = (i + 1) * (SETTLE + 2) + 1;
    end
    e.err      = cnt;
    e.pass     = (cnt == 0);
    e.last_idx = last[7:0];
    e.chk_in   = (num > 0);
    e.last_in  = (num > 0) ? tb_in[last] : 32'd0;
    return e;
  endfunction

  task automatic check_res(input int k, input exp_t e);
    chk($sformatf("d%0d.latency", k), cyc - e.start_cyc + 1, e.lat);
    chk($sformatf("d%0d.err_count", k), get_err(k), e.err);
    chk($sformatf("d%0d.pass", k), {31'd0, pass_s[k]}, {31'd0, e.pass});
    chk($sformatf("d%0d.ff_valid", k), {31'd0, ffv_s[k]}, {31'd0, e.ffv});
    chk($sformatf("d%0d.ff_idx", k), {24'd0, ffi_s[k]}, {24'd0, e.ffi});
    chk($sformatf("d%0d.ff_obs", k), ffo_s[k], e.ffo);
    chk($sformatf("d%0d.vec_idx", k), {24'd0, idx_s[k]}, {24'd0, e.last_idx});
    chk($sformatf("d%0d.busy_at_done", k), {31'd0, busy_s[k]}, 32'd0);
    if (e.chk_in) chk($sformatf("d%0d.dut_in_hold", k), din_s[k], e.last_in);
  endtask

  task automatic timeout_fail(input int k);
    total++;
    bad++;
    $display("FAIL d%0d.done_timeout: got done=0 want done=1 within %0d cycles",
             k, TMO);
  endtask

  // Monitors: one per DUT, each pops when its DUT presents done.
  always @(negedge clk2) begin
    if (q0.size() != 0 && cyc >= q0[0].start_cyc) begin
      if (done_s[0]) begin check_res(0, q0[0]); q0.delete(0); end
      else if (cyc - q0[0].start_cyc > TMO) begin timeout_fail(0); q0.delete(0); end
    end
  end

  always @(negedge clk2) begin
    if (q1.size() != 0 && cyc >= q1[0].start_cyc) begin
      if (done_s[1]) begin check_res(1, q1[0]); q1.delete(0); end
      else if (cyc - q1[0].start_cyc > TMO) begin timeout_fail(1); q1.delete(0); end
    end
  end

  always @(negedge clk2) begin
    if (q2.size() != 0 && cyc >= q2[0].start_cyc) begin
      if (done_s[2]) begin check_res(2, q2[0]); q2.delete(0); end
      else if (cyc - q2[0].start_cyc > TMO) begin timeout_fail(2); q2.delete(0); end
    end
  end

  task automatic load(input logic [7:0] addr, input logic flag,
                      input logic [31:0] in_w, input logic [31:0] exp_w);
    @(negedge clk2);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = {flag, in_w, exp_w};
    if (addr < DEPTH) begin
      tb_flag[addr] = flag;
      tb_in[addr]   = in_w;
      tb_exp[addr]  = exp_w;
    end
    @(negedge clk2);
    load_en = 1'b0;
  endtask

  task automatic run(input int num, input logic [31:0] mask);
    exp_t e;
    @(negedge clk2);
    num_vec  = num[8:0];
    cmp_mask = mask;
    start    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = model(k, num, mask);
      e.start_cyc = cyc + 1;
      if (k == 0) q0.push_back(e);
      else if (k == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    @(negedge clk2);
    start    = 1'b0;
    num_vec  = 9'($urandom);
    cmp_mask = $urandom;
    @(negedge clk2);
    if (num > 0) begin
      chk("apply.dut_in", din_s[0], tb_in[0]);
      chk("apply.dut_rst", {31'd0, drst_s[0]}, {31'd0, tb_flag[0]});
    end
    for (int w = 0; w < TMO + 20 && (q0.size() + q1.size() + q2.size()) != 0; w++)
      @(negedge clk2);
    @(negedge clk2);
  endtask

  task automatic check_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.d%0d.dut_in", k), din_s[k], 32'd0);
      chk($sformatf("rst.d%0d.dut_rst", k), {31'd0, drst_s[k]}, 32'd1);
      chk($sformatf("rst.d%0d.busy", k), {31'd0, busy_s[k]}, 32'd0);
      chk($sformatf("rst.d%0d.done", k), {31'd0, done_s[k]}, 32'd0);
      chk($sformatf("rst.d%0d.pass", k), {31'd0, pass_s[k]}, 32'd0);
      chk($sformatf("rst.d%0d.err", k), get_err(k), 32'd0);
      chk($sformatf("rst.d%0d.vec_idx", k), {24'd0, idx_s[k]}, 32'd0);
      chk($sformatf("rst.d%0d.ffv", k), {31'd0, ffv_s[k]}, 32'd0);
      chk($sformatf("rst.d%0d.ffi", k), {24'd0, ffi_s[k]}, 32'd0);
      chk($sformatf("rst.d%0d.ffo", k), ffo_s[k], 32'd0);
    end
  endtask

  task automatic load_basic();
    load(8'd0, 1'b0, 32'h1, 32'h1);
    load(8'd1, 1'b0, 32'h2, 32'h2);
    load(8'd2, 1'b0, 32'h3, 32'h3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] iw;
    logic [31:0] m;
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    num_vec = '0; start = 1'b0; cmp_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_flag[i] = 1'b0; tb_in[i] = '0; tb_exp[i] = '0;
    end
    repeat (3) @(negedge clk2);
    check_reset();
    rst = 1'b1;

    // Clean three-vector loopback run
    load_basic();
    run(3, 32'hFFFF_FFFF);
    // Vector 1 expects the wrong word
    load(8'd1, 1'b0, 32'h2, 32'h3);
    run(3, 32'hFFFF_FFFF);
    // Differing bit masked off
    run(3, 32'hFFFF_FFFE);
    // Flagged vector with wrong expectation is not scored
    load(8'd1, 1'b0, 32'h2, 32'h2);
    load(8'd0, 1'b1, 32'h1, 32'h55);
    run(3, 32'hFFFF_FFFF);
    // Empty run
    run(0, 32'hFFFF_FFFF);
    // Mismatch at index 0: early stop on d1
    load(8'd0, 1'b0, 32'h1, 32'h9);
    run(3, 32'hFFFF_FFFF);
    // Many mismatches: d2 counter saturates
    for (int i = 0; i < 6; i++) load(i[7:0], 1'b0, 32'(i + 16), 32'(i));
    run(6, 32'hFFFF_FFFF);

    // Abort by reset, with start and a table write attempted while busy
    load_basic();
    @(negedge clk2);
    num_vec = 9'd3; cmp_mask = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk2);
    start = 1'b0;
    repeat (3) @(negedge clk2);
    start = 1'b1; load_en = 1'b1; load_addr = 8'd0;
    load_data = {1'b0, 32'hDEAD, 32'hBEEF};
    @(negedge clk2);
    start = 1'b0; load_en = 1'b0; rst = 1'b0;
    @(negedge clk2);
    check_reset();
    rst = 1'b1;
    run(3, 32'hFFFF_FFFF);

    // Randomized runs, with occasional writes beyond the table
    for (int t = 0; t < 16; t++) begin
      n = (t % 5 == 4) ? 0 : $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        iw = $urandom;
        load(i[7:0], ($urandom_range(0, 7) == 0), iw,
             iw ^ (($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0));
      end
      if ($urandom_range(0, 1) == 1)
        load(8'($urandom_range(DEPTH, 255)), 1'b0, $urandom, $urandom);
      m = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      run(n, m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_vector_checker.md
Name: gpio_vector_checker

Overview:
Synthesizable on-chip successor to the GPIO vector bench. It holds a loadable table of test vectors, drives each vector's reset flag and input word into the DUT, and waits a programmable number of settle cycles. It then compares the DUT output against the expected word under a mask, counting mismatches and capturing the first failure. It sits beside the cpu, driving its gpio_in/rst and observing gpio_out, so regression runs without a simulator.

Parameters:
IN_W, 32, DUT input word width
OUT_W, 32, DUT output / expected word width
DEPTH, 150, vector table entries
ADDR_W, 8, index width; must satisfy 2^ADDR_W >= DEPTH
CNT_W, 16, error counter width
STOP_ON_FAIL, 0, 1 = finish the run at the first counted mismatch

Ports:
clk2  in  1  clock; all state changes on rising edge
rst  in  1  reset; synchronous, active-low
load_en  in  1  table write strobe
load_addr  in  ADDR_W  table write index
load_data  in  1+IN_W+OUT_W  vector {dut_rst_flag, in_word, exp_word}
num_vec  in  ADDR_W+1  vectors to run (0..DEPTH), sampled at start
start  in  1  begin run (one-cycle pulse)
cmp_mask  in  OUT_W  1 = bit compared; sampled at start
dut_out  in  OUT_W  observed DUT output
dut_in  out  IN_W  drive to DUT input
dut_rst  out  1  drive to DUT reset (active-high)
busy  out  1  run in progress
done  out  1  run finished; held until next start or reset
pass  out  1  valid when done: err_count==0
err_count  out  CNT_W  counted mismatches, saturating
vec_idx  out  ADDR_W  index currently applied
first_fail_valid  out  1  a mismatch has been captured
first_fail_idx  out  ADDR_W  index of first mismatch
first_fail_obs  out  OUT_W  dut_out at first mismatch

Behaviour:
- Reset (rst==0 at an edge): state IDLE; dut_in=0, dut_rst=1, busy=0, done=0, pass=0, err_count=0, vec_idx=0, first_fail_*=0. Table contents are not reset. Reset mid-run aborts the run at that edge.
- Table write: when load_en=1 in IDLE or DONE, table[load_addr] <= load_data. Writes while busy are ignored. Writes with load_addr >= DEPTH are ignored.
- States: IDLE, APPLY, SETTLE, CHECK, DONE. busy=1 in APPLY/SETTLE/CHECK.
- IDLE/DONE + start:
  - Latch num_vec and cmp_mask.
  - Clear err_count, first_fail_*, vec_idx, done and pass.
  - If num_vec==0, go to DONE with pass=1; otherwise go to APPLY.
- start while busy: ignored.
- APPLY (1 cycle):
  - dut_in <= table[vec_idx].in_word; dut_rst <= flag.
  - Settle counter <= SETTLE_CYCLES (constant 4 at DEPTH default build; generic parameter SETTLE, default 4, must be >= 1).
  - Go to SETTLE.
- SETTLE: decrement the counter; on the edge where counter==1, go to CHECK.
- CHECK (1 cycle):
  - Mismatch = ((dut_out ^ exp_word) & mask) != 0, evaluated only when the vector's dut_rst flag==0.
  - On mismatch: err_count += 1, saturating at 2^CNT_W-1. If first_fail_valid==0, capture idx and dut_out and set first_fail_valid.
  - If vec_idx==num_vec-1, or (STOP_ON_FAIL and a mismatch was counted): go to DONE, done=1, pass=(err_count after update==0).
  - Otherwise vec_idx += 1 and go to APPLY.
- Per-vector latency: SETTLE+2 cycles. done rises N*(SETTLE+2)+1 edges after the start edge.
- dut_in/dut_rst hold their last vector in DONE and IDLE.

Test Plan:
1. Load 3 vectors (flag 0; in=0x1,0x2,0x3; exp=in), DUT loopback, mask all-ones, num_vec=3, start -> done 19 cycles after start; err_count=0, pass=1, first_fail_valid=0.
2. Same as 1 but vector 1 exp=0x3 -> err_count=1, pass=0, first_fail_idx=1, first_fail_obs=0x2.
3. Same as 2 with cmp_mask=0xFFFFFFFE -> err_count=0, pass=1.
4. Vector 0 flag=1 with wrong exp -> dut_rst=1 during vector 0; mismatch not counted; err_count=0.
5. num_vec=0, start -> done=1 and pass=1 on the next edge; busy never asserts. STOP_ON_FAIL=1 build with mismatch at idx 0 of 3 -> done after 7 cycles, err_count=1.
6. Hold rst=0 mid-run, then start pulse and load_en while busy -> all outputs return to reset values; dropped writes leave table unchanged (verified by rerun).
